// File: rtl/alu_queue_pkg.sv
// Shared CPU types for the ALU execute stage: op encodings, bus payloads,
// the per-entry result-queue record and a leading-zero counter.
package alu_queue_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PHY_W     = 6;
  localparam int unsigned ROB_W_MAX = 8;
  localparam int unsigned EXCCODE_W = 5;
  localparam int unsigned BYP_WE_W  = 4;

  localparam logic [EXCCODE_W-1:0] EXCCODE_NONE = 5'h00;
  localparam logic [EXCCODE_W-1:0] EXCCODE_OV   = 5'h0c;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_SLT, ALU_SLTU,
    ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_LUI, ALU_CLZ, ALU_CLO, ALU_MOVN, ALU_MOVZ,
    ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO
  } alu_op_t;

  typedef struct packed {
    logic                 ex;
    logic [EXCCODE_W-1:0] exccode;
  } exception_t;

  // Everything the ALU datapath itself consumes
  typedef struct packed {
    alu_op_t             op;
    logic                src1_is_sa;
    logic                src2_is_simm;
    logic                src2_is_zimm;
    logic [15:0]         imm;
    logic [4:0]          sa;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [DATA_W-1:0]   old_value;
  } alu_core_in_t;

  typedef struct packed {
    alu_core_in_t           core;
    logic                   rf_we;
    logic [PHY_W-1:0]       phy_dest;
    logic [ROB_W_MAX-1:0]   rob_entry_num;
  } issue_to_execute_bus_t;

  typedef struct packed {
    logic [BYP_WE_W-1:0]  rf_we;
    logic [PHY_W-1:0]     phy_dest;
    logic [DATA_W-1:0]    result;
  } bypass_bus_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_store_op;
    logic                   verify_result;
    logic                   rf_we;
    logic [PHY_W-1:0]       phy_dest;
    logic [DATA_W-1:0]      result;
    logic [ROB_W_MAX-1:0]   rob_entry_num;
    exception_t             exception;
  } execute_to_commit_bus_t;

  typedef struct packed {
    logic [DATA_W-1:0]      result;
    logic                   rf_we;
    logic [PHY_W-1:0]       phy_dest;
    logic [ROB_W_MAX-1:0]   rob_entry_num;
    exception_t             exception;
  } alu_queue_entry_t;

  // Highest set bit wins; all-zero input yields 32
  function automatic logic [5:0] count_leading_zeros(input logic [DATA_W-1:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: operand selection, result and overflow exception.
module alu_core
  import alu_queue_pkg::*;
(
  input  alu_core_in_t       inst,
  output logic [DATA_W-1:0]  result,
  output exception_t         exception
);

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              ov;

  always_comb begin
    op1 = inst.src1_is_sa ? 32'(inst.sa) : inst.src1;
    if (inst.src2_is_simm)      op2 = {{16{inst.imm[15]}}, inst.imm};
    else if (inst.src2_is_zimm) op2 = {16'h0000, inst.imm};
    else                        op2 = inst.src2;
    // Sign-extended 33-bit adders: overflow when the two top bits disagree
    sum  = {op1[31], op1} + {op2[31], op2};
    diff = {op1[31], op1} - {op2[31], op2};
  end

  always_comb begin
    result = '0;
    ov     = 1'b0;
    case (inst.op)
      ALU_ADD:  begin result = sum[31:0];  ov = sum[32] ^ sum[31];   end
      ALU_ADDU: result = sum[31:0];
      ALU_SUB:  begin result = diff[31:0]; ov = diff[32] ^ diff[31]; end
      ALU_SUBU: result = diff[31:0];
      ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'd0, op1 < op2};
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_NOR:  result = ~(op1 | op2);
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLL:  result = op2 << op1[4:0];
      ALU_SRL:  result = op2 >> op1[4:0];
      ALU_SRA:  result = $signed(op2) >>> op1[4:0];
      ALU_LUI:  result = {op2[15:0], 16'h0000};
      ALU_CLZ:  result = 32'(count_leading_zeros(op1));
      ALU_CLO:  result = 32'(count_leading_zeros(~op1));
      ALU_MOVN: result = (op2 != '0) ? op1 : inst.old_value;
      ALU_MOVZ: result = (op2 == '0) ? op1 : inst.old_value;
      ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO: result = op1;
      default:  result = '0;
    endcase
  end

  always_comb begin
    exception.ex      = ov;
    exception.exccode = ov ? EXCCODE_OV : EXCCODE_NONE;
  end

endmodule

// File: rtl/alu_queue.sv
// ALU execute stage: computes on push and buffers results in a small in-order
// queue feeding the commit stage and the bypass network.
module alu_queue
  import alu_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          issue_to_alu_valid,
  output logic                          alu_allowin,
  input  issue_to_execute_bus_t         issue_inst,
  input  logic                          cs_allowin,
  output logic                          alu_to_valid,
  output bypass_bus_t                   alu_bypass_bus,
  output execute_to_commit_bus_t        alu_to_commit_bus,
  output logic [$clog2(DEPTH+1)-1:0]    alu_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;
  localparam logic [ROB_W_MAX-1:0] ROB_MASK = ROB_W_MAX'((64'd1 << ROB_W) - 64'd1);

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] core_result;
  exception_t        core_exception;
  alu_queue_entry_t  new_entry;
  alu_queue_entry_t  head_entry;
  alu_queue_entry_t  entries [SLOTS];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  alu_core u_alu_core (
    .inst      (issue_inst.core),
    .result    (core_result),
    .exception (core_exception)
  );

  // Ready depends only on registered occupancy, never on cs_allowin
  assign alu_allowin  = (count < CNT_W'(DEPTH));
  assign alu_to_valid = (count != '0);
  assign alu_count    = count;
  assign push = issue_to_alu_valid & alu_allowin & ~flush;
  assign pop  = alu_to_valid & cs_allowin & ~flush;

  always_comb begin
    new_entry.result        = core_result;
    new_entry.rf_we         = issue_inst.rf_we;
    new_entry.phy_dest      = issue_inst.phy_dest;
    new_entry.rob_entry_num = issue_inst.rob_entry_num & ROB_MASK;
    new_entry.exception     = core_exception;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides visibility
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= new_entry;
  end

  assign head_entry = entries[head];

  always_comb begin
    alu_bypass_bus.rf_we    = {BYP_WE_W{head_entry.rf_we & alu_to_valid}};
    alu_bypass_bus.phy_dest = head_entry.phy_dest;
    alu_bypass_bus.result   = head_entry.result;

    alu_to_commit_bus.valid         = alu_to_valid;
    alu_to_commit_bus.is_store_op   = 1'b0;
    alu_to_commit_bus.verify_result = 1'b0;
    alu_to_commit_bus.rf_we         = head_entry.rf_we;
    alu_to_commit_bus.phy_dest      = head_entry.phy_dest;
    alu_to_commit_bus.result        = head_entry.result;
    alu_to_commit_bus.rob_entry_num = head_entry.rob_entry_num;
    alu_to_commit_bus.exception     = head_entry.exception;
  end

endmodule

// File: tb/tb_alu_queue.sv
// Bench for alu_queue: DEPTH=4, 1 and 3 builds share stimulus; a queue-based
// reference model tracks each build's expected contents.
module tb_alu_queue;
  import alu_queue_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        ex;
    logic        rf_we;
    logic [5:0]  phy;
    logic [7:0]  rob;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush, iv, cs;
  issue_to_execute_bus_t  inst;
  logic                   allow_a  [3];
  logic                   valid_a  [3];
  logic [4:0]             cnt_a    [3];
  bypass_bus_t            byp_a    [3];
  execute_to_commit_bus_t commit_a [3];

  exp_t mq [3][$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 4 : (g == 1) ? 1 : 3;
    logic [$clog2(D+1)-1:0] cnt;
    alu_queue #(.DEPTH(D), .ROB_W(4)) u_dut (
      .clk(clk), .reset(reset), .flush(flush), .issue_to_alu_valid(iv),
      .alu_allowin(allow_a[g]), .issue_inst(inst), .cs_allowin(cs),
      .alu_to_valid(valid_a[g]), .alu_bypass_bus(byp_a[g]),
      .alu_to_commit_bus(commit_a[g]), .alu_count(cnt)
    );
    assign cnt_a[g] = 5'(cnt);
  end

  function automatic int dep_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 3;
  endfunction

  // Reference ALU straight from the instruction semantics
  function automatic exp_t model_alu(input issue_to_execute_bus_t t);
    exp_t e;
    logic [31:0] a, b, r;
    logic ov;
    int n;
    a = t.core.src1_is_sa ? {27'd0, t.core.sa} : t.core.src1;
    if (t.core.src2_is_simm)      b = {{16{t.core.imm[15]}}, t.core.imm};
    else if (t.core.src2_is_zimm) b = {16'd0, t.core.imm};
    else                          b = t.core.src2;
    r = 32'd0; ov = 1'b0; n = 0;
    case (t.core.op)
      ALU_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_ADDU: r = a + b;
      ALU_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_SUBU: r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_NOR:  r = ~(a | b);
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = b << a[4:0];
      ALU_SRL:  r = b >> a[4:0];
      ALU_SRA:  r = $signed(b) >>> a[4:0];
      ALU_LUI:  r = {b[15:0], 16'h0000};
      ALU_CLZ:  begin while (n < 32 && a[31-n] == 1'b0) n++; r = 32'(n); end
      ALU_CLO:  begin while (n < 32 && a[31-n] == 1'b1) n++; r = 32'(n); end
      ALU_MOVN: r = (b != 32'd0) ? a : t.core.old_value;
      ALU_MOVZ: r = (b == 32'd0) ? a : t.core.old_value;
      default:  r = a;
    endcase
    e.result = r; e.ex = ov; e.rf_we = t.rf_we;
    e.phy = t.phy_dest; e.rob = t.rob_entry_num & 8'h0f;
    return e;
  endfunction

  function automatic issue_to_execute_bus_t mk_inst(input alu_op_t op,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] old);
    issue_to_execute_bus_t t;
    t = '0;
    t.core.op = op; t.core.src1 = s1; t.core.src2 = s2; t.core.old_value = old;
    t.rf_we = 1'b1; t.phy_dest = 6'd9; t.rob_entry_num = 8'h13;
    return t;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7fff_ffff;
      3: return 32'h8000_0000;
      4: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic issue_to_execute_bus_t rand_inst();
    issue_to_execute_bus_t t;
    int r;
    t = '0;
    r = int'($urandom_range(0, 7));
    t.core.op = alu_op_t'(5'($urandom_range(0, 21)));
    t.core.src1_is_sa = (r == 0); t.core.src2_is_simm = (r == 1); t.core.src2_is_zimm = (r == 2);
    t.core.imm = 16'($urandom); t.core.sa = 5'($urandom);
    t.core.src1 = pick_val(); t.core.src2 = pick_val(); t.core.old_value = $urandom;
    t.rf_we = 1'($urandom); t.phy_dest = 6'($urandom); t.rob_entry_num = 8'($urandom);
    return t;
  endfunction

  // One clock: decide accept/retire from pre-edge state, then update the model
  task automatic tick();
    exp_t e;
    bit psh [3];
    bit pp  [3];
    e = model_alu(inst);
    for (int i = 0; i < 3; i++) begin
      psh[i] = iv && (mq[i].size() < dep_of(i)) && !flush;
      pp[i]  = (mq[i].size() > 0) && cs && !flush;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (flush) mq[i].delete();
      else begin
        if (pp[i]) void'(mq[i].pop_front());
        if (psh[i]) mq[i].push_back(e);
      end
    end
  endtask

  task automatic drain();
    iv = 1'b0; cs = 1'b1;
    repeat (6) tick();
    cs = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      vectors += 5;
      if (valid_a[g] !== 1'b0) begin miscompares++; $display("FAIL reset_valid d%0d got %b want 0", g, valid_a[g]); end
      if (allow_a[g] !== 1'b1) begin miscompares++; $display("FAIL reset_allowin d%0d got %b want 1", g, allow_a[g]); end
      if (cnt_a[g] !== 5'd0) begin miscompares++; $display("FAIL reset_count d%0d got %0d want 0", g, cnt_a[g]); end
      if (commit_a[g].valid !== 1'b0) begin miscompares++; $display("FAIL reset_commit_valid d%0d got %b want 0", g, commit_a[g].valid); end
      if (byp_a[g].rf_we !== 4'h0) begin miscompares++; $display("FAIL reset_byp_we d%0d got %h want 0", g, byp_a[g].rf_we); end
    end
  endtask

  task automatic test_addu_latency();
    inst = mk_inst(ALU_ADDU, 32'd5, 32'd7, 32'd0);
    iv = 1'b1; cs = 1'b1;
    vectors++;
    if (valid_a[0] !== 1'b0) begin miscompares++; $display("FAIL addu_passthru got %b want 0", valid_a[0]); end
    tick();
    iv = 1'b0;
    vectors += 7;
    if (valid_a[0] !== 1'b1) begin miscompares++; $display("FAIL addu_valid got %b want 1", valid_a[0]); end
    if (commit_a[0].result !== 32'd12) begin miscompares++; $display("FAIL addu_result got %h want 0000000c", commit_a[0].result); end
    if (cnt_a[0] !== 5'd1) begin miscompares++; $display("FAIL addu_count got %0d want 1", cnt_a[0]); end
    if (byp_a[0].rf_we !== 4'hf) begin miscompares++; $display("FAIL addu_byp_we got %h want f", byp_a[0].rf_we); end
    if (commit_a[0].rob_entry_num !== 8'h03) begin miscompares++; $display("FAIL addu_rob got %h want 03", commit_a[0].rob_entry_num); end
    if (commit_a[0].is_store_op !== 1'b0 || commit_a[0].verify_result !== 1'b0) begin
      miscompares++; $display("FAIL addu_flags got %b%b want 00", commit_a[0].is_store_op, commit_a[0].verify_result);
    end
    if (byp_a[0].phy_dest !== 6'd9) begin miscompares++; $display("FAIL addu_phy got %0d want 9", byp_a[0].phy_dest); end
    tick();
    vectors += 2;
    if (cnt_a[0] !== 5'd0) begin miscompares++; $display("FAIL addu_drain_count got %0d want 0", cnt_a[0]); end
    if (valid_a[0] !== 1'b0) begin miscompares++; $display("FAIL addu_drain_valid got %b want 0", valid_a[0]); end
  endtask

  task automatic test_overflow();
    cs = 1'b0; iv = 1'b1;
    inst = mk_inst(ALU_ADD, 32'h7fff_ffff, 32'd1, 32'd0);
    tick();
    iv = 1'b0;
    vectors += 3;
    if (commit_a[0].exception.ex !== 1'b1) begin miscompares++; $display("FAIL ov_ex got %b want 1", commit_a[0].exception.ex); end
    if (commit_a[0].exception.exccode !== EXCCODE_OV) begin miscompares++; $display("FAIL ov_code got %h want %h", commit_a[0].exception.exccode, EXCCODE_OV); end
    if (commit_a[0].result !== 32'h8000_0000) begin miscompares++; $display("FAIL ov_result got %h want 80000000", commit_a[0].result); end
    drain();
    iv = 1'b1;
    inst = mk_inst(ALU_SUB, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    iv = 1'b0;
    vectors += 2;
    if (commit_a[0].exception.ex !== 1'b1) begin miscompares++; $display("FAIL ov_sub_ex got %b want 1", commit_a[0].exception.ex); end
    if (commit_a[0].result !== 32'h7fff_ffff) begin miscompares++; $display("FAIL ov_sub_result got %h want 7fffffff", commit_a[0].result); end
    drain();
  endtask

  task automatic test_movz();
    cs = 1'b0; iv = 1'b1;
    inst = mk_inst(ALU_MOVZ, 32'h55, 32'd3, 32'hAA);
    tick();
    inst = mk_inst(ALU_MOVZ, 32'h55, 32'd0, 32'hAA);
    tick();
    iv = 1'b0;
    vectors += 2;
    if (commit_a[0].result !== 32'hAA) begin miscompares++; $display("FAIL movz_false got %h want 000000aa", commit_a[0].result); end
    if (cnt_a[0] !== 5'd2) begin miscompares++; $display("FAIL movz_count got %0d want 2", cnt_a[0]); end
    cs = 1'b1;
    tick();
    vectors++;
    if (commit_a[0].result !== 32'h55) begin miscompares++; $display("FAIL movz_true got %h want 00000055", commit_a[0].result); end
    drain();
  endtask

  task automatic test_fill_drain();
    int k;
    bit acc;
    int ec;
    k = 0; cs = 1'b0; iv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      inst = mk_inst(ALU_ADDU, 32'(k + 100), 32'd0, 32'd0);
      acc = allow_a[0];
      tick();
      if (acc) k++;
      for (int g = 0; g < 3; g++) begin
        ec = (c + 1 < dep_of(g)) ? c + 1 : dep_of(g);
        vectors += 2;
        if (cnt_a[g] !== 5'(ec)) begin miscompares++; $display("FAIL fill_count d%0d c%0d got %0d want %0d", g, c, cnt_a[g], ec); end
        if (allow_a[g] !== 1'(ec < dep_of(g))) begin miscompares++; $display("FAIL fill_allowin d%0d c%0d got %b", g, c, allow_a[g]); end
      end
    end
    vectors++;
    if (commit_a[0].result !== 32'd100) begin miscompares++; $display("FAIL fill_head got %h want 00000064", commit_a[0].result); end
    cs = 1'b1;
    for (int c = 0; c < 12; c++) begin
      inst = mk_inst(ALU_ADDU, 32'(k + 100), 32'd0, 32'd0);
      acc = allow_a[0];
      tick();
      if (acc) k++;
      for (int g = 0; g < 3; g++) begin
        vectors += 2;
        if (cnt_a[g] !== 5'(mq[g].size())) begin miscompares++; $display("FAIL drain_count d%0d c%0d got %0d want %0d", g, c, cnt_a[g], mq[g].size()); end
        if (valid_a[g] !== 1'(mq[g].size() > 0)) begin miscompares++; $display("FAIL drain_valid d%0d c%0d got %b", g, c, valid_a[g]); end
        if (mq[g].size() > 0) begin
          vectors++;
          if (commit_a[g].result !== mq[g][0].result) begin
            miscompares++; $display("FAIL drain_order d%0d c%0d got %h want %h", g, c, commit_a[g].result, mq[g][0].result);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_flush_full();
    cs = 1'b0; iv = 1'b1;
    repeat (4) begin inst = rand_inst(); tick(); end
    vectors += 2;
    if (allow_a[0] !== 1'b0) begin miscompares++; $display("FAIL full_allowin got %b want 0", allow_a[0]); end
    if (cnt_a[0] !== 5'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", cnt_a[0]); end
    flush = 1'b1; cs = 1'b1; inst = rand_inst();
    tick();
    flush = 1'b0; iv = 1'b0;
    for (int g = 0; g < 3; g++) begin
      vectors += 3;
      if (cnt_a[g] !== 5'd0) begin miscompares++; $display("FAIL flush_count d%0d got %0d want 0", g, cnt_a[g]); end
      if (valid_a[g] !== 1'b0) begin miscompares++; $display("FAIL flush_valid d%0d got %b want 0", g, valid_a[g]); end
      if (allow_a[g] !== 1'b1) begin miscompares++; $display("FAIL flush_allowin d%0d got %b want 1", g, allow_a[g]); end
    end
    tick();
    vectors++;
    if (valid_a[0] !== 1'b0) begin miscompares++; $display("FAIL flush_lost got %b want 0", valid_a[0]); end
  endtask

  task automatic test_async_reset();
    cs = 1'b0; iv = 1'b1;
    repeat (3) begin inst = rand_inst(); tick(); end
    iv = 1'b0;
    vectors++;
    if (cnt_a[0] !== 5'd3) begin miscompares++; $display("FAIL areset_pre_count got %0d want 3", cnt_a[0]); end
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      vectors += 2;
      if (valid_a[g] !== 1'b0) begin miscompares++; $display("FAIL areset_valid d%0d got %b want 0", g, valid_a[g]); end
      if (cnt_a[g] !== 5'd0) begin miscompares++; $display("FAIL areset_count d%0d got %0d want 0", g, cnt_a[g]); end
      mq[g].delete();
    end
    @(negedge clk);
    reset = 1'b0; cs = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (valid_a[g] !== 1'b0) begin miscompares++; $display("FAIL areset_reappear d%0d got %b want 0", g, valid_a[g]); end
    end
  endtask

  task automatic test_random();
    exp_t h;
    for (int c = 0; c < 400; c++) begin
      iv    = ($urandom_range(0, 3) != 0);
      cs    = ($urandom_range(0, 4) < 3);
      flush = ($urandom_range(0, 19) == 0);
      inst  = rand_inst();
      tick();
      for (int g = 0; g < 3; g++) begin
        vectors += 3;
        if (cnt_a[g] !== 5'(mq[g].size())) begin miscompares++; $display("FAIL rand_count d%0d c%0d got %0d want %0d", g, c, cnt_a[g], mq[g].size()); end
        if (valid_a[g] !== 1'(mq[g].size() > 0)) begin miscompares++; $display("FAIL rand_valid d%0d c%0d got %b", g, c, valid_a[g]); end
        if (allow_a[g] !== 1'(mq[g].size() < dep_of(g))) begin miscompares++; $display("FAIL rand_allowin d%0d c%0d got %b", g, c, allow_a[g]); end
        if (mq[g].size() > 0) begin
          h = mq[g][0];
          vectors += 5;
          if (commit_a[g].result !== h.result) begin miscompares++; $display("FAIL rand_result d%0d c%0d got %h want %h", g, c, commit_a[g].result, h.result); end
          if (commit_a[g].exception.ex !== h.ex) begin miscompares++; $display("FAIL rand_ex d%0d c%0d got %b want %b", g, c, commit_a[g].exception.ex, h.ex); end
          if (commit_a[g].exception.exccode !== (h.ex ? EXCCODE_OV : 5'd0)) begin miscompares++; $display("FAIL rand_exccode d%0d c%0d got %h", g, c, commit_a[g].exception.exccode); end
          if (byp_a[g].rf_we !== {4{h.rf_we}} || byp_a[g].phy_dest !== h.phy) begin
            miscompares++; $display("FAIL rand_bypass d%0d c%0d got %h/%0d want %h/%0d", g, c, byp_a[g].rf_we, byp_a[g].phy_dest, {4{h.rf_we}}, h.phy);
          end
          if (commit_a[g].rob_entry_num !== h.rob) begin miscompares++; $display("FAIL rand_rob d%0d c%0d got %h want %h", g, c, commit_a[g].rob_entry_num, h.rob); end
        end
      end
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; iv = 1'b0; cs = 1'b0; inst = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_addu_latency();
    test_overflow();
    test_movz();
    test_fill_drain();
    test_flush_full();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_queue.md
ALU_QUEUE -- requirements
Module: alu_queue

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries (legal 1..16; need not be a power of two).
REQ-002 Parameter ROB_W, default 4, width of rob_entry_num.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 issue_to_alu_valid  input  1  issue stage offers an instruction.
REQ-007 alu_allowin  output  1  queue can accept this cycle.
REQ-008 issue_inst  input  issue_to_execute_bus_t  decoded inst, phy_dest, src1/src2/old values, rob_entry_num.
REQ-009 cs_allowin  input  1  commit stage accepts head entry.
REQ-010 alu_to_valid  output  1  head entry valid.
REQ-011 alu_bypass_bus  output  bypass_bus_t  {4x rf_we, phy_dest, result} of head entry.
REQ-012 alu_to_commit_bus  output  execute_to_commit_bus_t  head entry to commit.
REQ-013 alu_count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 push = issue_to_alu_valid & alu_allowin & ~flush; pop = alu_to_valid & cs_allowin & ~flush.
REQ-015 alu_allowin = (count < DEPTH), from registered count only; no combinational path cs_allowin -> alu_allowin.
REQ-016 ALU computes on issue_inst in the push cycle; queue stores result, rf_we, phy_dest, rob_entry_num, exception per entry.
REQ-017 Latency: push in cycle N into empty queue -> alu_to_valid=1 with that result in cycle N+1; no same-cycle pass-through.
REQ-018 Operations: ADD/ADDU/SUB/SUBU/SLT/SLTU/AND/OR/NOR/XOR/SLL/SRL/SRA/LUI/CLZ/CLO/MOVN/MOVZ/MFHI/MFLO/MTHI/MTLO, identical 32-bit semantics to existing ALU; src1_is_sa, src2_is_simm, src2_is_zimm operand selection; shift amount = src1[4:0].
REQ-019 ADD/SUB signed overflow (33-bit adder, bit32 ^ bit31) -> exception.ex=1, exccode=EXCCODE_OV; result still stored.
REQ-020 MOVZ/MOVN with condition false -> result = old_value; rf_we unchanged.
REQ-021 FIFO order strict; head/tail pointers wrap from DEPTH-1 to 0.
REQ-022 Count: push&~pop +1, pop&~push -1, both -> unchanged; full queue blocks push even if pop same cycle.
REQ-023 Simultaneous push and pop when count=1: new entry becomes head in next cycle.
REQ-024 flush: count, head, tail -> 0 next cycle; same-cycle push and pop discarded.
REQ-025 alu_to_commit_bus.valid = alu_to_valid; is_store_op=0; verify_result=0; other fields from head entry.
REQ-026 Bypass rf_we = {4{head.rf_we & alu_to_valid}}; all bus data fields don't-care when invalid.

Reset
REQ-027 Reset asynchronous: count=0, head=0, tail=0 immediately.
REQ-028 Reset outputs: alu_to_valid=0, alu_allowin=1, alu_count=0, commit valid=0, bypass rf_we=0.
REQ-029 Entry storage not reset; invisible while invalid.
REQ-030 Reset asserted mid-operation discards all entries; no entry reappears after release.

Structure
REQ-031 alu_state/op encodings, EXCCODE_OV, issue_to_execute_bus_t, execute_to_commit_bus_t, bypass_bus_t stay in shared cpu package; new type alu_queue_entry_t added there.
REQ-032 Combinational compute in one sub-module alu_core (inst, operands in; result, exception out); alu_queue holds queue and control.

Verification
REQ-033 ADDU 5+7 pushed into empty queue, cs_allowin=1 -> next cycle alu_to_valid=1, result=12, count=1, then 0.
REQ-034 ADD 0x7FFFFFFF+1 -> exception.ex=1, exccode=EXCCODE_OV, result=0x80000000.
REQ-035 cs_allowin=0, push 4 entries (DEPTH=4) -> alu_allowin=0 after 4th; 5th offered held; release cs_allowin -> entries drain in order, pointers wrap correctly over 10 ops.
REQ-036 Full queue, flush with valid push -> next cycle count=0, alu_to_valid=0, alu_allowin=1, pushed inst lost.
REQ-037 MOVZ src2=3, old=0xAA, src1=0x55 -> result 0xAA; MOVZ src2=0 -> 0x55.
REQ-038 Assert reset asynchronously between clock edges with count=3 -> alu_to_valid drops before next edge; DEPTH=1 and DEPTH=3 builds repeat REQ-035.
